// File: rtl/strait_pkg.sv
// Types and default array geometry shared by the activation feeder, skew buffer and array.
package strait_pkg;

    localparam int DEF_SYSTOLIC_SIZE    = 8;
    localparam int DEF_ACTIVATION_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        READY,
        STREAM,
        FLUSH,
        DONE
    } feeder_state_t;

endpackage

// File: rtl/act_tile_ram.sv
// Tile row storage: synchronous write, combinational read, storage is never reset.
module act_tile_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 64,
    parameter int AW    = 4
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/activation_feeder.sv
// Stages one activation tile and streams it row by row into the skew buffer,
// appending SYSTOLIC_SIZE-1 zero cycles in skewed mode so the deepest skew row drains.
module activation_feeder
    import strait_pkg::*;
#(
    parameter int  SYSTOLIC_SIZE    = DEF_SYSTOLIC_SIZE,
    parameter int  ACTIVATION_WIDTH = DEF_ACTIVATION_WIDTH,
    parameter int  TILE_DEPTH       = 16,
    localparam int CNT_W            = $clog2(TILE_DEPTH + 1)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   test_mode,
    input  logic                                   wr_valid,
    output logic                                   wr_ready,
    input  logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0] wr_data,
    input  logic                                   wr_last,
    input  logic                                   start,
    output logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0] activation_data,
    output logic                                   act_valid,
    output logic                                   busy,
    output logic                                   tile_done,
    output logic [CNT_W-1:0]                       row_count
);

    localparam int ROW_W = SYSTOLIC_SIZE * ACTIVATION_WIDTH;
    localparam int AW    = (TILE_DEPTH > 1) ? $clog2(TILE_DEPTH) : 1;
    localparam int FW    = (SYSTOLIC_SIZE > 1) ? $clog2(SYSTOLIC_SIZE) : 1;
    localparam bit HAS_FLUSH = (SYSTOLIC_SIZE > 1);
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(TILE_DEPTH);
    localparam logic [FW-1:0]    FLUSH_LAST = FW'((SYSTOLIC_SIZE > 1) ? SYSTOLIC_SIZE - 2 : 0);

    feeder_state_t    state_q, state_d;
    logic [CNT_W-1:0] row_cnt_q, row_cnt_d;
    logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]    flush_cnt_q, flush_cnt_d;
    logic             mode_q, mode_d;
    logic [ROW_W-1:0] act_data_q, act_data_d;
    logic             act_valid_q, act_valid_d;

    logic             wr_fire;
    logic             last_row;
    logic [CNT_W-1:0] rd_next;
    logic [AW-1:0]    raddr;
    logic [ROW_W-1:0] rdata;

    assign wr_ready = (state_q == LOAD) && (row_cnt_q < DEPTH_C);
    assign wr_fire  = wr_valid && wr_ready;
    assign rd_next  = rd_ptr_q + CNT_W'(1);
    assign last_row = (rd_ptr_q == row_cnt_q - CNT_W'(1));
    // Read one row ahead so the next row is registered onto the output edge.
    assign raddr    = (state_q == READY) ? '0 : rd_next[AW-1:0];

    act_tile_ram #(
        .DEPTH (TILE_DEPTH),
        .WIDTH (ROW_W),
        .AW    (AW)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (wr_fire),
        .waddr_i (row_cnt_q[AW-1:0]),
        .wdata_i (wr_data),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        rd_ptr_d    = rd_ptr_q;
        flush_cnt_d = flush_cnt_q;
        mode_d      = mode_q;
        act_data_d  = '0;
        act_valid_d = 1'b0;
        case (state_q)
            IDLE: state_d = LOAD;
            LOAD: begin
                if (wr_fire) begin
                    row_cnt_d = row_cnt_q + CNT_W'(1);
                    if (wr_last || (row_cnt_d == DEPTH_C)) begin
                        state_d = READY;
                    end
                end
            end
            READY: begin
                if (start) begin
                    mode_d      = test_mode;
                    rd_ptr_d    = '0;
                    act_data_d  = rdata;
                    act_valid_d = 1'b1;
                    state_d     = STREAM;
                end
            end
            STREAM: begin
                if (last_row) begin
                    flush_cnt_d = '0;
                    state_d     = (!mode_q && HAS_FLUSH) ? FLUSH : DONE;
                end else begin
                    rd_ptr_d    = rd_next;
                    act_data_d  = rdata;
                    act_valid_d = 1'b1;
                end
            end
            FLUSH: begin
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d = DONE;
                end else begin
                    flush_cnt_d = flush_cnt_q + FW'(1);
                end
            end
            DONE: begin
                row_cnt_d = '0;
                rd_ptr_d  = '0;
                state_d   = LOAD;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            row_cnt_q   <= '0;
            rd_ptr_q    <= '0;
            flush_cnt_q <= '0;
            mode_q      <= 1'b0;
            act_data_q  <= '0;
            act_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            flush_cnt_q <= flush_cnt_d;
            mode_q      <= mode_d;
            act_data_q  <= act_data_d;
            act_valid_q <= act_valid_d;
        end
    end

    assign activation_data = act_data_q;
    assign act_valid       = act_valid_q;
    assign busy            = (state_q == STREAM) || (state_q == FLUSH) || (state_q == DONE);
    assign tile_done       = (state_q == DONE);
    assign row_count       = row_cnt_q;

endmodule

// File: tb/tb_activation_feeder.sv
// Scoreboard bench for activation_feeder: stimulus pushes expected row/done events, a monitor pops them.
module tb_activation_feeder;

    localparam int SS = 8;
    localparam int AWD = 8;
    localparam int TD = 16;
    localparam int W = SS * AWD;
    localparam int CW = $clog2(TD + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          test_mode = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_last = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  wr_data = '0;
    logic          wr_ready;
    logic [W-1:0]  activation_data;
    logic          act_valid;
    logic          busy;
    logic          tile_done;
    logic [CW-1:0] row_count;

    typedef struct {
        bit           is_done;
        logic [W-1:0] data;
        int           cyc;
    } ev_t;

    ev_t          exp_q[$];
    ev_t          mon_e;
    logic [W-1:0] mrows[$];
    bit           mload = 1'b0;
    int           cyc = 0;
    int           n_chk = 0;
    int           n_fail = 0;

    activation_feeder #(
        .SYSTOLIC_SIZE    (SS),
        .ACTIVATION_WIDTH (AWD),
        .TILE_DEPTH       (TD)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .test_mode       (test_mode),
        .wr_valid        (wr_valid),
        .wr_ready        (wr_ready),
        .wr_data         (wr_data),
        .wr_last         (wr_last),
        .start           (start),
        .activation_data (activation_data),
        .act_valid       (act_valid),
        .busy            (busy),
        .tile_done       (tile_done),
        .row_count       (row_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, required %0b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every presented row or completion pulse must match the next expected event.
    always @(negedge clk) begin
        if (rst_n && (act_valid || tile_done)) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_output: got valid=%0b done=%0b, required no output (cycle %0d)",
                         act_valid, tile_done, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk1("event_is_done", tile_done, mon_e.is_done);
                chki("event_cycle", cyc, mon_e.cyc);
                if (!mon_e.is_done) chk("row_data", activation_data, mon_e.data);
            end
        end else if (rst_n) begin
            chk("idle_data_zero", activation_data, '0);
        end
    end

    task automatic write_row(input logic [W-1:0] d, input bit last, input bit er);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = d;
        wr_last  = last;
        #1 chk1("wr_ready", wr_ready, er);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic load_tile(input int n, input bit use_last, input bit gaps, input bit directed);
        for (int i = 0; i < n; i++) begin
            logic [W-1:0] d;
            bit last;
            bit er;
            if (gaps && ($urandom_range(0, 3) == 0)) @(negedge clk);
            d    = directed ? {8{8'(i + 1)}} : {$urandom, $urandom};
            last = use_last && (i == n - 1);
            er   = mload && (mrows.size() < TD);
            write_row(d, last, er);
            if (er) begin
                mrows.push_back(d);
                if (last || (mrows.size() == TD)) mload = 1'b0;
            end
        end
        @(negedge clk);
        chki("row_count_loaded", int'(row_count), mrows.size());
    endtask

    // pert: 0 none, 1 flip test_mode mid-stream, 2 write attempts during stream
    task automatic run_tile(input bit mode, input int pert);
        int s;
        int r;
        bit got;
        r = mrows.size();
        @(negedge clk);
        start     = 1'b1;
        test_mode = mode;
        s         = cyc;
        for (int i = 0; i < r; i++) exp_q.push_back('{1'b0, mrows[i], s + 1 + i});
        exp_q.push_back('{1'b1, {W{1'b0}}, mode ? s + r + 1 : s + r + SS});
        mrows.delete();
        got = 1'b0;
        for (int k = 0; k < 4 * TD + 4 * SS && !got; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (pert == 1 && cyc == s + 2) test_mode = ~mode;
            if (pert == 2) begin
                wr_valid = (cyc <= s + r);
                if (wr_valid) begin
                    wr_data = {$urandom, $urandom};
                    #1 chk1("wr_ready_stream", wr_ready, 1'b0);
                    chki("row_count_stream", int'(row_count), r);
                end
            end
            if (tile_done) got = 1'b1;
        end
        wr_valid = 1'b0;
        chk1("tile_done_seen", got, 1'b1);
        mload = 1'b1;
        @(negedge clk);
        chki("row_count_cleared", int'(row_count), 0);
        chk1("wr_ready_after_done", wr_ready, 1'b1);
        chk1("busy_after_done", busy, 1'b0);
    endtask

    task automatic mid_reset();
        int s;
        load_tile(4, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        start     = 1'b1;
        test_mode = 1'b0;
        s         = cyc;
        for (int i = 0; i < 4; i++) exp_q.push_back('{1'b0, mrows[i], s + 1 + i});
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_data", activation_data, '0);
        chk1("rst_mid_valid", act_valid, 1'b0);
        chk1("rst_mid_busy", busy, 1'b0);
        chk1("rst_mid_wr_ready", wr_ready, 1'b0);
        chki("rst_mid_row_count", int'(row_count), 0);
        exp_q.delete();
        mrows.delete();
        mload = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk1("wr_ready_idle_after_rst", wr_ready, 1'b0);
        @(negedge clk);
        mload = 1'b1;
        load_tile(1, 1'b1, 1'b0, 1'b0);
        run_tile(1'b0, 0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_data", activation_data, '0);
            chk1("rst_act_valid", act_valid, 1'b0);
            chk1("rst_tile_done", tile_done, 1'b0);
            chk1("rst_busy", busy, 1'b0);
            chk1("rst_wr_ready", wr_ready, 1'b0);
            chki("rst_row_count", int'(row_count), 0);
        end
        rst_n = 1'b1;
        #1 chk1("wr_ready_idle", wr_ready, 1'b0);
        @(negedge clk);
        chk1("wr_ready_after_reset", wr_ready, 1'b1);
        chk1("busy_after_reset", busy, 1'b0);
        mload = 1'b1;

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk1("act_valid_start_in_load", act_valid, 1'b0);
        chk1("wr_ready_still_load", wr_ready, 1'b1);

        load_tile(3, 1'b1, 1'b0, 1'b1);
        run_tile(1'b0, 1);
        load_tile(3, 1'b1, 1'b0, 1'b1);
        run_tile(1'b1, 2);

        load_tile(TD, 1'b0, 1'b0, 1'b0);
        write_row({$urandom, $urandom}, 1'b0, 1'b0);
        chki("row_count_full", int'(row_count), TD);
        run_tile(1'b0, 0);

        mid_reset();

        repeat (20) begin
            n = int'($urandom_range(1, TD));
            load_tile(n, (n < TD) || ($urandom_range(0, 1) == 1), 1'b1, 1'b0);
            run_tile($urandom_range(0, 1) == 1, int'($urandom_range(0, 2)));
        end

        repeat (3) @(negedge clk);
        chki("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete within time limit (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
